// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage registers.
// Holds the slot-occupancy state encoding and the control-bundle layouts and
// bubble values for each CPU stage boundary. A bubble carries no register
// write and no memory access, so consumers that ignore valid stay safe.
package pipe_pkg;

  // Occupancy of a two-slot stage; the encoding doubles as the count output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_t;

  // ID/EX control bundle: {ALUOp[1:0], ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg}
  localparam int ID_EX_CTRL_W       = 7;
  localparam int ID_EX_ALUOP_LSB    = 5;
  localparam int ID_EX_ALUSRC_BIT   = 4;
  localparam int ID_EX_REGWRITE_BIT = 3;
  localparam int ID_EX_MEMWRITE_BIT = 2;
  localparam int ID_EX_MEMREAD_BIT  = 1;
  localparam int ID_EX_MEMTOREG_BIT = 0;
  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_BUBBLE = '0;

  // EX/MEM control bundle: {RegWrite, MemWrite, MemRead, MemtoReg}
  localparam int EX_MEM_CTRL_W       = 4;
  localparam int EX_MEM_REGWRITE_BIT = 3;
  localparam int EX_MEM_MEMWRITE_BIT = 2;
  localparam int EX_MEM_MEMREAD_BIT  = 1;
  localparam int EX_MEM_MEMTOREG_BIT = 0;
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE = '0;

  // MEM/WB control bundle: {RegWrite, MemtoReg}
  localparam int MEM_WB_CTRL_W       = 2;
  localparam int MEM_WB_REGWRITE_BIT = 1;
  localparam int MEM_WB_MEMTOREG_BIT = 0;
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE = '0;

  // IF/ID carries only a "slot holds a real instruction" flag as control.
  localparam int IF_ID_CTRL_W = 1;
  localparam logic [IF_ID_CTRL_W-1:0] IF_ID_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a control register plus a data register.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   load                capture next_ctrl/next_data
//   bubble              replace the control value with BUBBLE_CTRL, data held
//   next_ctrl/next_data values captured on load
//   ctrl/data           current slot contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 7,
  parameter int                DATA_W      = 128,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DATA_W-1:0] next_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Bubble wins over load so a flush always neutralises the control bundle;
  // data is left alone on a bubble because nothing reads it without valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= BUBBLE_CTRL;
      data <= '0;
    end else if (bubble) begin
      ctrl <= BUBBLE_CTRL;
    end else if (load) begin
      ctrl <= next_ctrl;
      data <= next_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a 2-entry skid buffer.
// Carries a control and a data bundle between CPU stages with valid/ready flow
// control. in_ready_o depends only on registered state and start_i, never on
// out_ready_i, so long ready chains are broken at every stage.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   start_i                   run enable; low freezes the stage
//   flush_i                   synchronous flush to an empty, bubbled stage
//   in_valid_i/in_ready_o     upstream handshake, ctrl_i/data_i payload
//   out_valid_o/out_ready_i   downstream handshake, ctrl_o/data_o payload
//   count_o                   occupancy 0..2
//   stall_cnt_o               saturating count of cycles upstream was blocked
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 7,
  parameter int                DATA_W      = 128,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  slot_state_t       state_q, state_d;
  logic              in_fire, out_fire;
  logic              main_load, main_bubble, main_from_skid;
  logic              skid_load, skid_bubble;
  logic [CTRL_W-1:0] skid_ctrl, main_next_ctrl;
  logic [DATA_W-1:0] skid_data, main_next_data;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign in_ready_o  = start_i && (state_q != TWO);
  assign out_valid_o = start_i && (state_q != EMPTY);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign count_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

  // The main slot refills either from upstream or, when draining TWO, from skid.
  assign main_next_ctrl = main_from_skid ? skid_ctrl : ctrl_i;
  assign main_next_data = main_from_skid ? skid_data : data_i;

  // Next-state and slot-control decode. Flush overrides everything, even a
  // frozen stage; an out_fire in the flush cycle has already been delivered.
  // With start_i low both fires are gated off, so every branch holds.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_bubble    = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_bubble    = 1'b0;
    if (flush_i) begin
      state_d     = EMPTY;
      main_bubble = 1'b1;
      skid_bubble = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_bubble = 1'b1;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_bubble    = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts blocked upstream cycles, including those caused by start_i low,
  // and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (in_valid_i && !in_ready_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .BUBBLE_CTRL(BUBBLE_CTRL)
  ) u_main (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (main_load),
    .bubble   (main_bubble),
    .next_ctrl(main_next_ctrl),
    .next_data(main_next_data),
    .ctrl     (ctrl_o),
    .data     (data_o)
  );

  pipe_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .BUBBLE_CTRL(BUBBLE_CTRL)
  ) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (skid_load),
    .bubble   (skid_bubble),
    .next_ctrl(ctrl_i),
    .next_data(data_i),
    .ctrl     (skid_ctrl),
    .data     (skid_data)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. A reference FIFO model is fed on
// every accepted input; each delivered output is paired with the model head.
// A second instance with a 2-bit stall counter shares the stimulus.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 7;
  localparam int DATA_W = 128;
  localparam logic [CTRL_W-1:0] BUBBLE = 7'h00;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, start, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        count;
  logic [15:0]       stall_cnt;

  logic              in_ready2, out_valid2;
  logic [CTRL_W-1:0] ctrl_out2;
  logic [DATA_W-1:0] data_out2;
  logic [1:0]        count2;
  logic [1:0]        stall_cnt2;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  entry_t model_q[$];
  entry_t exp_q[$];
  entry_t got_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .ctrl_i(ctrl_in), .data_i(data_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .ctrl_o(ctrl_out), .data_o(data_out),
    .count_o(count), .stall_cnt_o(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready2), .ctrl_i(ctrl_in), .data_i(data_in),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .ctrl_o(ctrl_out2), .data_o(data_out2),
    .count_o(count2), .stall_cnt_o(stall_cnt2)
  );

  // Inputs change just after posedge, so the negedge view is what the next
  // posedge will act on. Delivery pops the model head; flush empties the model
  // and drops that cycle's input; reset wipes everything.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (model_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output got=%h expected=none", {ctrl_out, data_out});
        end else begin
          exp_q.push_back(model_q.pop_front());
          got_q.push_back({ctrl_out, data_out});
        end
      end
      if (flush) model_q.delete();
      else if (in_valid && in_ready) model_q.push_back({ctrl_in, data_in});
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d expected=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b expected=0", out_valid); end
    checks++; if (ctrl_out !== BUBBLE) begin failures++; $display("[TB] FAIL reset_ctrl got=%h expected=%h", ctrl_out, BUBBLE); end
    checks++; if (data_out !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h expected=0", data_out); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_stall got=%0d expected=0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b expected=1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    exp_stall = 0;
  endtask

  task automatic test_stream();
    entry_t g, e;
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; ctrl_in = 7'h5A; data_in = 128'h11 + 128'(i);
      @(posedge clk); #1;
      checks++; if (count !== 2'd1) begin failures++; $display("[TB] FAIL stream_count[%0d] got=%0d expected=1", i, count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_in_ready[%0d] got=%b expected=1", i, in_ready); end
      checks++; if (data_out !== 128'h11 + 128'(i)) begin failures++; $display("[TB] FAIL stream_data[%0d] got=%h expected=%h", i, data_out, 128'h11 + 128'(i)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL stream_drain_count got=%0d expected=0", count); end
    checks++; if (ctrl_out !== BUBBLE) begin failures++; $display("[TB] FAIL stream_empty_ctrl got=%h expected=%h", ctrl_out, BUBBLE); end
    checks++; if (got_q.size() !== 4) begin failures++; $display("[TB] FAIL stream_deliveries got=%0d expected=4", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL stream_order got=%h expected=%h", g, e); end
    end
  endtask

  task automatic test_backpressure();
    entry_t g, e;
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl_in = 7'h11; data_in = 128'hA0;
    @(posedge clk); #1;
    checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_after_a got count=%0d ready=%b expected count=1 ready=1", count, in_ready); end
    ctrl_in = 7'h22; data_in = 128'hB0;
    @(posedge clk); #1;
    checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_after_b got count=%0d ready=%b expected count=2 ready=0", count, in_ready); end
    ctrl_in = 7'h33; data_in = 128'hC0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      exp_stall++;
      checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("[TB] FAIL bp_stall got=%0d expected=%0d", stall_cnt, exp_stall); end
      checks++; if (count !== 2'd2 || data_out !== 128'hA0) begin failures++; $display("[TB] FAIL bp_hold got count=%0d data=%h expected count=2 data=a0", count, data_out); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_stall++;
    checks++; if (count !== 2'd1 || data_out !== 128'hB0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release got count=%0d data=%h ready=%b expected count=1 data=b0 ready=1", count, data_out, in_ready); end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("[TB] FAIL bp_release_stall got=%0d expected=%0d", stall_cnt, exp_stall); end
    @(posedge clk); #1;
    checks++; if (count !== 2'd1 || data_out !== 128'hC0) begin failures++; $display("[TB] FAIL bp_accept_c got count=%0d data=%h expected count=1 data=c0", count, data_out); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained got count=%0d valid=%b expected 0 0", count, out_valid); end
    checks++; if (got_q.size() !== 3) begin failures++; $display("[TB] FAIL bp_deliveries got=%0d expected=3", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL bp_order got=%h expected=%h", g, e); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl_in = 7'h44; data_in = 128'hD0;
    @(posedge clk); #1;
    ctrl_in = 7'h55; data_in = 128'hE0;
    @(posedge clk); #1;
    checks++; if (count !== 2'd2) begin failures++; $display("[TB] FAIL flush_setup got=%0d expected=2", count); end
    ctrl_in = 7'h66; data_in = 128'hF0; flush = 1'b1;
    @(posedge clk); #1;
    exp_stall++;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_state got count=%0d valid=%b expected 0 0", count, out_valid); end
    checks++; if (ctrl_out !== BUBBLE) begin failures++; $display("[TB] FAIL flush_ctrl got=%h expected=%h", ctrl_out, BUBBLE); end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("[TB] FAIL flush_stall got=%0d expected=%0d", stall_cnt, exp_stall); end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 2'd0 || got_q.size() !== 0) begin failures++; $display("[TB] FAIL flush_dropped got count=%0d deliveries=%0d expected 0 0", count, got_q.size()); end
  endtask

  task automatic test_start_gate();
    entry_t g, e;
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl_in = 7'h77; data_in = 128'h1234;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1; ctrl_in = 7'h78; data_in = 128'h5678;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL gate_handshake got ready=%b valid=%b expected 0 0", in_ready, out_valid); end
    repeat (2) @(posedge clk);
    #1;
    exp_stall += 2;
    checks++; if (count !== 2'd1 || data_out !== 128'h1234) begin failures++; $display("[TB] FAIL gate_hold got count=%0d data=%h expected count=1 data=1234", count, data_out); end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("[TB] FAIL gate_stall got=%0d expected=%0d", stall_cnt, exp_stall); end
    start = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL gate_resume_valid got=%b expected=1", out_valid); end
    @(posedge clk); #1;
    checks++; if (count !== 2'd0 || got_q.size() !== 1) begin failures++; $display("[TB] FAIL gate_delivery got count=%0d deliveries=%0d expected 0 1", count, got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL gate_entry got=%h expected=%h", g, e); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl_in = 7'h0F; data_in = 128'hAAAA;
    @(posedge clk); #1;
    ctrl_in = 7'h70; data_in = 128'hBBBB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL areset_state got count=%0d valid=%b expected 0 0", count, out_valid); end
    checks++; if (ctrl_out !== BUBBLE || data_out !== '0) begin failures++; $display("[TB] FAIL areset_slot got ctrl=%h data=%h expected ctrl=%h data=0", ctrl_out, data_out, BUBBLE); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL areset_stall got=%0d expected=0", stall_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall_saturation();
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl_in = 7'h01; data_in = 128'h1;
    @(posedge clk); #1;
    data_in = 128'h2;
    @(posedge clk); #1;
    data_in = 128'h3;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      checks++; if (stall_cnt2 !== 2'((k > 3) ? 3 : k)) begin failures++; $display("[TB] FAIL sat_stall2[%0d] got=%0d expected=%0d", k, stall_cnt2, (k > 3) ? 3 : k); end
      checks++; if (stall_cnt !== 16'(k)) begin failures++; $display("[TB] FAIL sat_stall16[%0d] got=%0d expected=%0d", k, stall_cnt, k); end
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_start_gate();
    test_async_reset();
    test_stall_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
